fetch_ctrl: RTL



---
 rtl/fetch_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch stage: owns the PC, drives the ROM pointer and registers the fetched word toward decode.
// Optional self-loop halt detection is enabled with FETCH_HALT_DETECT_EN (adds the halted output).
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pointer,
  input  logic [31:0] ins_in,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins,
  output logic        trap,
  output logic [1:0]  trap_cause,
`ifdef FETCH_HALT_DETECT_EN
  output logic        halted,
`endif
  output logic [31:0] trap_pc
);

  // state | meaning
  // RUN   | fetching normally, subject to stall and decode backpressure
  // TRAP  | sticky fault; only reset leaves it
  // HALT  | self-loop seen; no fetches until a redirect (optional build only)
  typedef enum logic [1:0] {
    RUN,
`ifdef FETCH_HALT_DETECT_EN
    HALT,
`endif
    TRAP
  } state_t;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] NOP_INS  = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic        accept;

  assign pointer = pc;
  assign accept  = (state == RUN) && !stall && !redirect_valid && (!if_valid || if_ready);

`ifdef FETCH_HALT_DETECT_EN
  // JAL to itself, or a zero-offset branch comparing a register with itself.
  function automatic logic is_self_loop(input logic [31:0] w);
    logic jal_loop;
    logic br_loop;
    jal_loop = (w[6:0] == 7'b1101111) && (w[31:12] == 20'h0);
    br_loop  = (w[6:0] == 7'b1100011) && (w[31:25] == 7'h0) && (w[11:7] == 5'h0) &&
               (w[19:15] == w[24:20]);
    return jal_loop || br_loop;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_ins     <= NOP_INS;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      trap_pc    <= 32'h0;
`ifdef FETCH_HALT_DETECT_EN
      halted     <= 1'b0;
`endif
    end else if (state != TRAP) begin
      if (redirect_valid) begin
        // A redirect flushes even an output decode is accepting this cycle.
        if_valid <= 1'b0;
        if (redirect_target[1:0] == 2'b00) begin
          pc    <= redirect_target;
          state <= RUN;
`ifdef FETCH_HALT_DETECT_EN
          halted <= 1'b0;
`endif
        end else begin
          state      <= TRAP;
          trap       <= 1'b1;
          trap_cause <= 2'b01;
          trap_pc    <= redirect_target;
        end
      end else if (accept) begin
        if (pc < PC_LIMIT) begin
          if_valid <= 1'b1;
          if_pc    <= pc;
          if_ins   <= ins_in;
          pc       <= pc + 32'd4;
`ifdef FETCH_HALT_DETECT_EN
          if (is_self_loop(ins_in)) begin
            state  <= HALT;
            halted <= 1'b1;
          end
`endif
        end else begin
          state      <= TRAP;
          trap       <= 1'b1;
          trap_cause <= 2'b10;
          trap_pc    <= pc;
          if_valid   <= 1'b0;
        end
      end else if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule
